// File: rtl/basic_axi4_lite_master.sv
// rtl/basic_axi4_lite_master.sv - AXI4-Lite single-outstanding initiator bridging user commands to AW/W/B and AR/R
// Optional watchdog abort is compiled in with AXI4L_MASTER_TIMEOUT_EN.

module basic_axi4_lite_master #(
  parameter int p_ADDRESS_WIDTH = 2,
  parameter int p_DATA_WIDTH    = 8,
`ifdef AXI4L_MASTER_TIMEOUT_EN
  parameter int p_TIMEOUT_CYCLES = 16,
`endif
  localparam int lp_STROBE_WIDTH = (p_DATA_WIDTH >= 8) ? (p_DATA_WIDTH / 8) : 1
) (
  input  logic                       i_ACLK,
  input  logic                       i_ARESETN,
  input  logic                       i_CMD_VALID,
  output logic                       o_CMD_READY,
  input  logic                       i_CMD_WRITE,
  input  logic [p_ADDRESS_WIDTH-1:0] i_CMD_ADDR,
  input  logic [p_DATA_WIDTH-1:0]    i_CMD_WDATA,
  input  logic [lp_STROBE_WIDTH-1:0] i_CMD_WSTRB,
  input  logic [2:0]                 i_CMD_PROT,
  output logic                       o_RSP_VALID,
  input  logic                       i_RSP_READY,
  output logic                       o_RSP_WRITE,
  output logic [1:0]                 o_RSP_RESP,
  output logic [p_DATA_WIDTH-1:0]    o_RSP_RDATA,
  output logic [p_ADDRESS_WIDTH-1:0] o_M_AWADDR,
  output logic [2:0]                 o_M_AWPROT,
  output logic                       o_M_AWVALID,
  input  logic                       i_S_AWREADY,
  output logic [p_DATA_WIDTH-1:0]    o_M_WDATA,
  output logic [lp_STROBE_WIDTH-1:0] o_M_WSTRB,
  output logic                       o_M_WVALID,
  input  logic                       i_S_WREADY,
  input  logic [1:0]                 i_S_BRESP,
  input  logic                       i_S_BVALID,
  output logic                       o_M_BREADY,
  output logic [p_ADDRESS_WIDTH-1:0] o_M_ARADDR,
  output logic [2:0]                 o_M_ARPROT,
  output logic                       o_M_ARVALID,
  input  logic                       i_S_ARREADY,
  input  logic [p_DATA_WIDTH-1:0]    i_S_RDATA,
  input  logic [1:0]                 i_S_RRESP,
  input  logic                       i_S_RVALID,
  output logic                       o_M_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR_DATA,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_RESPOND
  } state_t;

  state_t                     state_q, state_d;
  logic                       aw_pend_q, aw_pend_d;
  logic                       w_pend_q, w_pend_d;
  logic                       is_write_q, is_write_d;
  logic [p_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [p_DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [lp_STROBE_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [2:0]                 prot_q, prot_d;
  logic                       rsp_write_q, rsp_write_d;
  logic [1:0]                 rsp_resp_q, rsp_resp_d;
  logic [p_DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                       tmo_hit;

`ifdef AXI4L_MASTER_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic        waiting;

  assign waiting = (state_q != S_IDLE) && (state_q != S_RESPOND);
  assign tmo_hit = waiting && (tmo_cnt_q == 16'(p_TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_ACLK or negedge i_ARESETN) begin
    if (!i_ARESETN) begin
      tmo_cnt_q <= 16'd0;
    end else if (state_d != state_q) begin
      tmo_cnt_q <= 16'd0;
    end else if (waiting) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge i_ACLK or negedge i_ARESETN) begin
    if (!i_ARESETN) begin
      state_q     <= S_IDLE;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      prot_q      <= 3'd0;
      rsp_write_q <= 1'b0;
      rsp_resp_q  <= 2'd0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      is_write_q  <= is_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      prot_q      <= prot_d;
      rsp_write_q <= rsp_write_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    aw_pend_d   = aw_pend_q;
    w_pend_d    = w_pend_q;
    is_write_d  = is_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    prot_d      = prot_q;
    rsp_write_d = rsp_write_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (i_CMD_VALID) begin
          is_write_d = i_CMD_WRITE;
          addr_d     = i_CMD_ADDR;
          wdata_d    = i_CMD_WDATA;
          wstrb_d    = i_CMD_WSTRB;
          prot_d     = i_CMD_PROT;
          if (i_CMD_WRITE) begin
            state_d   = S_WR_ADDR_DATA;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
          end else begin
            state_d = S_RD_ADDR;
          end
        end
      end
      S_WR_ADDR_DATA: begin
        // AW and W retire independently; leave only once both have handshaked.
        if (aw_pend_q && i_S_AWREADY) aw_pend_d = 1'b0;
        if (w_pend_q && i_S_WREADY) w_pend_d = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (i_S_BVALID) begin
          rsp_write_d = 1'b1;
          rsp_resp_d  = i_S_BRESP;
          rsp_rdata_d = '0;
          state_d     = S_RESPOND;
        end
      end
      S_RD_ADDR: begin
        if (i_S_ARREADY) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (i_S_RVALID) begin
          rsp_write_d = 1'b0;
          rsp_resp_d  = i_S_RRESP;
          rsp_rdata_d = i_S_RDATA;
          state_d     = S_RESPOND;
        end
      end
      S_RESPOND: begin
        if (i_RSP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog abort overrides whatever the slave did this cycle.
    if (tmo_hit) begin
      state_d     = S_RESPOND;
      aw_pend_d   = 1'b0;
      w_pend_d    = 1'b0;
      rsp_write_d = is_write_q;
      rsp_resp_d  = 2'b10;
      rsp_rdata_d = '0;
    end
  end

  // Every VALID/READY is a decode of registered state, never of a READY input.
  assign o_CMD_READY = (state_q == S_IDLE);
  assign o_M_AWVALID = aw_pend_q;
  assign o_M_WVALID  = w_pend_q;
  assign o_M_BREADY  = (state_q == S_WR_RESP);
  assign o_M_ARVALID = (state_q == S_RD_ADDR);
  assign o_M_RREADY  = (state_q == S_RD_DATA);
  assign o_RSP_VALID = (state_q == S_RESPOND);

  assign o_M_AWADDR  = addr_q;
  assign o_M_AWPROT  = prot_q;
  assign o_M_WDATA   = wdata_q;
  assign o_M_WSTRB   = wstrb_q;
  assign o_M_ARADDR  = addr_q;
  assign o_M_ARPROT  = prot_q;
  assign o_RSP_WRITE = rsp_write_q;
  assign o_RSP_RESP  = rsp_resp_q;
  assign o_RSP_RDATA = rsp_rdata_q;

endmodule

// File: tb/tb_basic_axi4_lite_master.sv
// tb/tb_basic_axi4_lite_master.sv - scoreboard bench for basic_axi4_lite_master with a delay-configurable slave
module tb_basic_axi4_lite_master;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int SW = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          i_CMD_VALID = 0, i_CMD_WRITE = 0, i_RSP_READY = 0;
  logic [AW-1:0] i_CMD_ADDR = '0;
  logic [DW-1:0] i_CMD_WDATA = '0;
  logic [SW-1:0] i_CMD_WSTRB = '0;
  logic [2:0]    i_CMD_PROT = '0;
  logic          o_CMD_READY, o_RSP_VALID, o_RSP_WRITE;
  logic [1:0]    o_RSP_RESP;
  logic [DW-1:0] o_RSP_RDATA;
  logic [AW-1:0] o_M_AWADDR, o_M_ARADDR;
  logic [2:0]    o_M_AWPROT, o_M_ARPROT;
  logic          o_M_AWVALID, o_M_WVALID, o_M_BREADY, o_M_ARVALID, o_M_RREADY;
  logic [DW-1:0] o_M_WDATA;
  logic [SW-1:0] o_M_WSTRB;
  logic          s_awready = 0, s_wready = 0, s_bvalid = 0, s_arready = 0, s_rvalid = 0;
  logic [1:0]    s_bresp = 0, s_rresp = 0;
  logic [DW-1:0] s_rdata = 0;

  basic_axi4_lite_master dut (
    .i_ACLK(clk), .i_ARESETN(rst_n),
    .i_CMD_VALID(i_CMD_VALID), .o_CMD_READY(o_CMD_READY), .i_CMD_WRITE(i_CMD_WRITE),
    .i_CMD_ADDR(i_CMD_ADDR), .i_CMD_WDATA(i_CMD_WDATA), .i_CMD_WSTRB(i_CMD_WSTRB),
    .i_CMD_PROT(i_CMD_PROT), .o_RSP_VALID(o_RSP_VALID), .i_RSP_READY(i_RSP_READY),
    .o_RSP_WRITE(o_RSP_WRITE), .o_RSP_RESP(o_RSP_RESP), .o_RSP_RDATA(o_RSP_RDATA),
    .o_M_AWADDR(o_M_AWADDR), .o_M_AWPROT(o_M_AWPROT), .o_M_AWVALID(o_M_AWVALID),
    .i_S_AWREADY(s_awready), .o_M_WDATA(o_M_WDATA), .o_M_WSTRB(o_M_WSTRB),
    .o_M_WVALID(o_M_WVALID), .i_S_WREADY(s_wready), .i_S_BRESP(s_bresp),
    .i_S_BVALID(s_bvalid), .o_M_BREADY(o_M_BREADY), .o_M_ARADDR(o_M_ARADDR),
    .o_M_ARPROT(o_M_ARPROT), .o_M_ARVALID(o_M_ARVALID), .i_S_ARREADY(s_arready),
    .i_S_RDATA(s_rdata), .i_S_RRESP(s_rresp), .i_S_RVALID(s_rvalid), .o_M_RREADY(o_M_RREADY)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          wr;
    logic [1:0]    resp;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int            lat, aw_c, w_c, b_c, ar_c, r_c;
    logic          issue_ready, payload_bad, bready_early, busy_ready, hold_bad, post_bad;
    logic          wr;
    logic [1:0]    resp;
    logic [DW-1:0] rdata;
  } obs_t;

  // Slave: each READY/VALID rises after its configured number of wait cycles.
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  logic [1:0]    bresp_cfg = 0, rresp_cfg = 0;
  logic [DW-1:0] rdata_cfg = 0;

  always @(negedge clk) begin
    if (o_M_AWVALID) begin s_awready = (aw_wait >= aw_delay); aw_wait++; end
    else begin s_awready = 0; aw_wait = 0; end
    if (o_M_WVALID) begin s_wready = (w_wait >= w_delay); w_wait++; end
    else begin s_wready = 0; w_wait = 0; end
    if (o_M_BREADY) begin s_bvalid = (b_wait >= b_delay); b_wait++; end
    else begin s_bvalid = 0; b_wait = 0; end
    if (o_M_ARVALID) begin s_arready = (ar_wait >= ar_delay); ar_wait++; end
    else begin s_arready = 0; ar_wait = 0; end
    if (o_M_RREADY) begin s_rvalid = (r_wait >= r_delay); r_wait++; end
    else begin s_rvalid = 0; r_wait = 0; end
    s_bresp = bresp_cfg;
    s_rresp = rresp_cfg;
    s_rdata = rdata_cfg;
  end

  task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] wstrb, input logic [2:0] prot, input int hold,
                         output obs_t ob);
    ob = '{lat: -1, aw_c: 0, w_c: 0, b_c: 0, ar_c: 0, r_c: 0, issue_ready: 0, payload_bad: 0,
           bready_early: 0, busy_ready: 0, hold_bad: 0, post_bad: 0, wr: 0, resp: 0, rdata: 0};
    @(negedge clk);
    ob.issue_ready = o_CMD_READY;
    i_CMD_VALID = 1; i_CMD_WRITE = wr; i_CMD_ADDR = addr;
    i_CMD_WDATA = wdata; i_CMD_WSTRB = wstrb; i_CMD_PROT = prot;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 1) i_CMD_VALID = 0;
      if (o_M_AWVALID) begin
        ob.aw_c++;
        if (o_M_AWADDR !== addr || o_M_AWPROT !== prot) ob.payload_bad = 1;
      end
      if (o_M_WVALID) begin
        ob.w_c++;
        if (o_M_WDATA !== wdata || o_M_WSTRB !== wstrb) ob.payload_bad = 1;
      end
      if (o_M_ARVALID) begin
        ob.ar_c++;
        if (o_M_ARADDR !== addr || o_M_ARPROT !== prot) ob.payload_bad = 1;
      end
      if (o_M_BREADY) begin
        ob.b_c++;
        if (o_M_AWVALID || o_M_WVALID) ob.bready_early = 1;
      end
      if (o_M_RREADY) ob.r_c++;
      if (o_CMD_READY) ob.busy_ready = 1;
      if (o_RSP_VALID) begin ob.lat = n; break; end
    end
    if (ob.lat < 0) return;
    ob.wr = o_RSP_WRITE; ob.resp = o_RSP_RESP; ob.rdata = o_RSP_RDATA;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (o_RSP_VALID !== 1 || o_RSP_WRITE !== ob.wr || o_RSP_RESP !== ob.resp ||
          o_RSP_RDATA !== ob.rdata || o_CMD_READY !== 0) ob.hold_bad = 1;
    end
    i_RSP_READY = 1;
    @(negedge clk);
    i_RSP_READY = 0;
    if (o_RSP_VALID !== 0 || o_CMD_READY !== 1) ob.post_bad = 1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({o_M_AWVALID, o_M_WVALID, o_M_BREADY, o_M_ARVALID, o_M_RREADY} !== 5'b0) begin
      errors++; $display("FAIL reset_axi_handshake: got %b expected 00000",
        {o_M_AWVALID, o_M_WVALID, o_M_BREADY, o_M_ARVALID, o_M_RREADY});
    end
    checks++;
    if ({o_RSP_VALID, o_RSP_WRITE, o_RSP_RESP, o_RSP_RDATA} !== '0) begin
      errors++; $display("FAIL reset_rsp: got valid=%b write=%b resp=%0d rdata=%0h expected all 0",
        o_RSP_VALID, o_RSP_WRITE, o_RSP_RESP, o_RSP_RDATA);
    end
    checks++;
    if ({o_M_AWADDR, o_M_WDATA, o_M_WSTRB, o_M_AWPROT} !== '0) begin
      errors++; $display("FAIL reset_payload: got addr=%0h data=%0h strb=%0h prot=%0h expected 0",
        o_M_AWADDR, o_M_WDATA, o_M_WSTRB, o_M_AWPROT);
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (o_CMD_READY !== 1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", o_CMD_READY); end
  endtask

  task automatic test_write_basic();
    obs_t ob; exp_t e;
    aw_delay = 0; w_delay = 0; b_delay = 0; bresp_cfg = 2'b00;
    sb_q.push_back('{wr: 1, resp: 2'b00, rdata: 8'h00});
    run_txn(1, 2'b01, 8'hA5, 1'b1, 3'b010, 0, ob);
    e = sb_q.pop_front();
    checks++; if (ob.issue_ready !== 1) begin errors++; $display("FAIL wr_issue_ready: got %b expected 1", ob.issue_ready); end
    checks++; if (ob.lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", ob.lat); end
    checks++; if (ob.aw_c !== 1 || ob.w_c !== 1) begin errors++; $display("FAIL wr_valid_cycles: got aw=%0d w=%0d expected 1 1", ob.aw_c, ob.w_c); end
    checks++; if (ob.payload_bad !== 0) begin errors++; $display("FAIL wr_payload: got bad=%b expected 0", ob.payload_bad); end
    checks++; if ({ob.wr, ob.resp, ob.rdata} !== {e.wr, e.resp, e.rdata}) begin
      errors++; $display("FAIL wr_response: got w=%b r=%0d d=%0h expected w=%b r=%0d d=%0h", ob.wr, ob.resp, ob.rdata, e.wr, e.resp, e.rdata); end
    checks++; if (ob.post_bad !== 0) begin errors++; $display("FAIL wr_post_handshake: got bad=%b expected 0", ob.post_bad); end
  endtask

  task automatic test_write_aw_delay();
    obs_t ob; exp_t e;
    aw_delay = 4; w_delay = 0; b_delay = 0; bresp_cfg = 2'b00;
    sb_q.push_back('{wr: 1, resp: 2'b00, rdata: 8'h00});
    run_txn(1, 2'b10, 8'h5A, 1'b1, 3'b101, 0, ob);
    e = sb_q.pop_front();
    checks++; if (ob.aw_c !== 5 || ob.w_c !== 1) begin errors++; $display("FAIL awdly_valid_cycles: got aw=%0d w=%0d expected 5 1", ob.aw_c, ob.w_c); end
    checks++; if (ob.payload_bad !== 0) begin errors++; $display("FAIL awdly_payload_stable: got bad=%b expected 0", ob.payload_bad); end
    checks++; if (ob.bready_early !== 0 || ob.b_c !== 1) begin errors++; $display("FAIL awdly_bready: got early=%b cycles=%0d expected 0 1", ob.bready_early, ob.b_c); end
    checks++; if (ob.lat !== 7) begin errors++; $display("FAIL awdly_latency: got %0d expected 7", ob.lat); end
    checks++; if ({ob.wr, ob.resp, ob.rdata} !== {e.wr, e.resp, e.rdata}) begin
      errors++; $display("FAIL awdly_response: got w=%b r=%0d d=%0h expected w=%b r=%0d d=%0h", ob.wr, ob.resp, ob.rdata, e.wr, e.resp, e.rdata); end
    aw_delay = 0;
  endtask

  task automatic test_read_wait();
    obs_t ob; exp_t e;
    ar_delay = 0; r_delay = 2; rdata_cfg = 8'h3C; rresp_cfg = 2'b00;
    sb_q.push_back('{wr: 0, resp: 2'b00, rdata: 8'h3C});
    run_txn(0, 2'b11, 8'h00, 1'b0, 3'b001, 0, ob);
    e = sb_q.pop_front();
    checks++; if (ob.lat !== 5) begin errors++; $display("FAIL rd_latency: got %0d expected 5", ob.lat); end
    checks++; if (ob.ar_c !== 1 || ob.r_c !== 3) begin errors++; $display("FAIL rd_handshake_cycles: got ar=%0d rready=%0d expected 1 3", ob.ar_c, ob.r_c); end
    checks++; if (ob.payload_bad !== 0) begin errors++; $display("FAIL rd_payload: got bad=%b expected 0", ob.payload_bad); end
    checks++; if ({ob.wr, ob.resp, ob.rdata} !== {e.wr, e.resp, e.rdata}) begin
      errors++; $display("FAIL rd_response: got w=%b r=%0d d=%0h expected w=%b r=%0d d=%0h", ob.wr, ob.resp, ob.rdata, e.wr, e.resp, e.rdata); end
    r_delay = 0;
  endtask

  task automatic test_read_err_hold();
    obs_t ob; exp_t e;
    rdata_cfg = 8'hC7; rresp_cfg = 2'b11;
    sb_q.push_back('{wr: 0, resp: 2'b11, rdata: 8'hC7});
    run_txn(0, 2'b00, 8'h00, 1'b0, 3'b000, 3, ob);
    e = sb_q.pop_front();
    checks++; if ({ob.wr, ob.resp, ob.rdata} !== {e.wr, e.resp, e.rdata}) begin
      errors++; $display("FAIL rderr_response: got w=%b r=%0d d=%0h expected w=%b r=%0d d=%0h", ob.wr, ob.resp, ob.rdata, e.wr, e.resp, e.rdata); end
    checks++; if (ob.hold_bad !== 0) begin errors++; $display("FAIL rderr_rsp_hold: got bad=%b expected 0", ob.hold_bad); end
    checks++; if (ob.busy_ready !== 0) begin errors++; $display("FAIL rderr_cmd_ready_busy: got %b expected 0", ob.busy_ready); end
    checks++; if (ob.post_bad !== 0) begin errors++; $display("FAIL rderr_post_handshake: got bad=%b expected 0", ob.post_bad); end
    rresp_cfg = 2'b00;
  endtask

  task automatic test_reset_mid();
    obs_t ob; exp_t e;
    logic reached;
    reached = 0;
    b_delay = 50;
    @(negedge clk);
    i_CMD_VALID = 1; i_CMD_WRITE = 1; i_CMD_ADDR = 2'b10; i_CMD_WDATA = 8'hEE; i_CMD_WSTRB = 1'b1; i_CMD_PROT = 3'b111;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) i_CMD_VALID = 0;
      if (o_M_BREADY) begin reached = 1; break; end
    end
    checks++; if (reached !== 1) begin errors++; $display("FAIL rstmid_reach_wr_resp: got %b expected 1", reached); end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({o_M_AWVALID, o_M_WVALID, o_M_BREADY, o_M_ARVALID, o_M_RREADY, o_RSP_VALID} !== 6'b0) begin
      errors++; $display("FAIL rstmid_outputs: got %b expected 000000",
        {o_M_AWVALID, o_M_WVALID, o_M_BREADY, o_M_ARVALID, o_M_RREADY, o_RSP_VALID});
    end
    checks++; if (o_CMD_READY !== 1) begin errors++; $display("FAIL rstmid_idle: got cmd_ready=%b expected 1", o_CMD_READY); end
    repeat (2) @(negedge clk);
    rst_n = 1; b_delay = 0;
    @(negedge clk);
    checks++; if (o_CMD_READY !== 1 || o_M_BREADY !== 0) begin
      errors++; $display("FAIL rstmid_release: got cmd_ready=%b bready=%b expected 1 0", o_CMD_READY, o_M_BREADY); end
    rdata_cfg = 8'h96;
    sb_q.push_back('{wr: 0, resp: 2'b00, rdata: 8'h96});
    run_txn(0, 2'b01, 8'h00, 1'b0, 3'b000, 0, ob);
    e = sb_q.pop_front();
    checks++; if (ob.lat !== 3 || {ob.wr, ob.resp, ob.rdata} !== {e.wr, e.resp, e.rdata}) begin
      errors++; $display("FAIL rstmid_next_read: got lat=%0d w=%b r=%0d d=%0h expected lat=3 w=%b r=%0d d=%0h",
        ob.lat, ob.wr, ob.resp, ob.rdata, e.wr, e.resp, e.rdata); end
  endtask

  task automatic test_back_to_back();
    obs_t ob; exp_t e;
    int exp_lat;
    logic wr;
    logic [DW-1:0] d;
    for (int i = 0; i < 10; i++) begin
      wr = 1'($urandom_range(1));
      d = 8'($urandom);
      aw_delay = $urandom_range(3); w_delay = $urandom_range(3); b_delay = $urandom_range(3);
      ar_delay = $urandom_range(3); r_delay = $urandom_range(3);
      bresp_cfg = 2'($urandom); rresp_cfg = 2'($urandom); rdata_cfg = 8'($urandom);
      if (wr) begin
        exp_lat = 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay;
        sb_q.push_back('{wr: 1, resp: bresp_cfg, rdata: 8'h00});
      end else begin
        exp_lat = 3 + ar_delay + r_delay;
        sb_q.push_back('{wr: 0, resp: rresp_cfg, rdata: rdata_cfg});
      end
      run_txn(wr, 2'($urandom), d, 1'($urandom), 3'($urandom), $urandom_range(2), ob);
      e = sb_q.pop_front();
      checks++; if (ob.lat !== exp_lat) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, ob.lat, exp_lat); end
      checks++; if ({ob.wr, ob.resp, ob.rdata} !== {e.wr, e.resp, e.rdata} || ob.payload_bad || ob.hold_bad || ob.post_bad) begin
        errors++; $display("FAIL b2b_response[%0d]: got w=%b r=%0d d=%0h flags=%b%b%b expected w=%b r=%0d d=%0h flags=000",
          i, ob.wr, ob.resp, ob.rdata, ob.payload_bad, ob.hold_bad, ob.post_bad, e.wr, e.resp, e.rdata); end
    end
    aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
  endtask

`ifdef AXI4L_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    obs_t ob; exp_t e;
    ar_delay = 1000; rdata_cfg = 8'hFF;
    sb_q.push_back('{wr: 0, resp: 2'b10, rdata: 8'h00});
    run_txn(0, 2'b10, 8'h00, 1'b0, 3'b000, 0, ob);
    e = sb_q.pop_front();
    checks++; if (ob.ar_c !== 16) begin errors++; $display("FAIL tmo_arvalid_cycles: got %0d expected 16", ob.ar_c); end
    checks++; if ({ob.wr, ob.resp, ob.rdata} !== {e.wr, e.resp, e.rdata}) begin
      errors++; $display("FAIL tmo_response: got w=%b r=%0d d=%0h expected w=%b r=%0d d=%0h", ob.wr, ob.resp, ob.rdata, e.wr, e.resp, e.rdata); end
    ar_delay = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_write_basic();
    test_write_aw_delay();
    test_read_wait();
    test_read_err_hold();
    test_reset_mid();
    test_back_to_back();
`ifdef AXI4L_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
